// File: rtl/pong_pkg.sv
// Shared types and direction encodings for the Pong ball datapath.
package pong_pkg;

  typedef enum logic {
    SERVE = 1'b0,
    PLAY  = 1'b1
  } state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
  localparam logic DIR_UP    = 1'b0;
  localparam logic DIR_DOWN  = 1'b1;

endpackage

// File: rtl/speed_ramp.sv
// Counts honoured paddle returns and raises a saturating speed level
// every SPEEDUP_HITS returns.
module speed_ramp #(
  parameter int MAX_SPEED    = 3,
  parameter int SPEEDUP_HITS = 4,
  parameter int LEVEL_WIDTH  = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   hit,
  input  logic                   clear,
  output logic [LEVEL_WIDTH-1:0] level
);

  localparam int CW = $clog2(SPEEDUP_HITS + 1);
  localparam logic [CW-1:0]          HIT_LAST  = CW'(SPEEDUP_HITS - 1);
  localparam logic [LEVEL_WIDTH-1:0] LEVEL_TOP = LEVEL_WIDTH'(MAX_SPEED);

  logic [CW-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
      level <= '0;
    end else if (hit) begin
      if (count == HIT_LAST) begin
        count <= '0;
        if (level != LEVEL_TOP)
          level <= level + 1'b1;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ball_kinematics.sv
// Ball-motion engine: serve FSM, wall/paddle bounces, clamped motion and
// miss detection, advanced once per frame tick.
module ball_kinematics
  import pong_pkg::*;
#(
  parameter int X_WIDTH       = 8,
  parameter int Y_WIDTH       = 9,
  parameter int X_START       = 115,
  parameter int Y_START       = 240,
  parameter int X_MIN         = 20,
  parameter int X_MAX         = 220,
  parameter int Y_MIN         = 175,
  parameter int Y_MAX         = 310,
  parameter int BASE_VELOCITY = 1,
  parameter int MAX_SPEED     = 3,
  parameter int SPEEDUP_HITS  = 4,
  parameter int SERVE_DELAY   = 60
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             stepEnable,
  input  logic                             paddleHitLeft,
  input  logic                             paddleHitRight,
  input  logic [1:0]                       changeYDirection,
  output logic [X_WIDTH-1:0]               ballXValue,
  output logic [Y_WIDTH-1:0]               ballYValue,
  output logic                             xDirection,
  output logic                             yDirection,
  output logic [$clog2(MAX_SPEED+1)-1:0]   speedLevel,
  output logic                             inPlay,
  output logic                             missLeft,
  output logic                             missRight
);

  localparam int LW = $clog2(MAX_SPEED + 1);
  localparam int SW = $clog2(SERVE_DELAY + 1);

  localparam logic [X_WIDTH:0]   XMIN_E     = (X_WIDTH+1)'(X_MIN);
  localparam logic [X_WIDTH:0]   XMAX_E     = (X_WIDTH+1)'(X_MAX);
  localparam logic [Y_WIDTH:0]   YMIN_E     = (Y_WIDTH+1)'(Y_MIN);
  localparam logic [Y_WIDTH:0]   YMAX_E     = (Y_WIDTH+1)'(Y_MAX);
  localparam logic [X_WIDTH-1:0] XSTART     = X_WIDTH'(X_START);
  localparam logic [Y_WIDTH-1:0] YSTART     = Y_WIDTH'(Y_START);
  localparam logic [SW-1:0]      SERVE_LAST = SW'(SERVE_DELAY - 1);

  state_t               state, state_nx;
  logic [SW-1:0]        serve_cnt, serve_nx;
  logic [X_WIDTH-1:0]   x_nx;
  logic [Y_WIDTH-1:0]   y_nx;
  logic                 xdir_nx, ydir_nx, miss_l_nx, miss_r_nx;
  logic                 hit_left, hit_right, miss_l, miss_r;
  logic                 ramp_hit, ramp_clear;
  logic [X_WIDTH:0]     vx, x_sum;
  logic [Y_WIDTH:0]     vy, y_sum;

  speed_ramp #(
    .MAX_SPEED    (MAX_SPEED),
    .SPEEDUP_HITS (SPEEDUP_HITS),
    .LEVEL_WIDTH  (LW)
  ) u_speed_ramp (
    .clock (clock),
    .reset (reset),
    .hit   (ramp_hit),
    .clear (ramp_clear),
    .level (speedLevel)
  );

  assign inPlay = (state == PLAY);

  always_comb begin
    state_nx   = state;
    serve_nx   = serve_cnt;
    x_nx       = ballXValue;
    y_nx       = ballYValue;
    xdir_nx    = xDirection;
    ydir_nx    = yDirection;
    miss_l_nx  = 1'b0;
    miss_r_nx  = 1'b0;
    ramp_hit   = 1'b0;
    ramp_clear = 1'b0;
    hit_left   = paddleHitLeft  && (xDirection == DIR_LEFT);
    hit_right  = paddleHitRight && (xDirection == DIR_RIGHT);
    miss_l     = ({1'b0, ballXValue} == XMIN_E) && (xDirection == DIR_LEFT)  && !hit_left;
    miss_r     = ({1'b0, ballXValue} == XMAX_E) && (xDirection == DIR_RIGHT) && !hit_right;
    vx         = (X_WIDTH+1)'(BASE_VELOCITY) + (X_WIDTH+1)'(speedLevel);
    vy         = (Y_WIDTH+1)'(BASE_VELOCITY) + (Y_WIDTH+1)'(speedLevel);
    x_sum      = '0;
    y_sum      = '0;

    if (stepEnable) begin
      case (state)
        SERVE: begin
          if (serve_cnt == SERVE_LAST) begin
            state_nx = PLAY;
            serve_nx = '0;
          end else begin
            serve_nx = serve_cnt + 1'b1;
          end
        end
        PLAY: begin
          if (miss_l || miss_r) begin
            miss_l_nx  = miss_l;
            miss_r_nx  = miss_r;
            x_nx       = XSTART;
            xdir_nx    = miss_l ? DIR_LEFT : DIR_RIGHT;
            ramp_clear = 1'b1;
            state_nx   = SERVE;
          end else begin
            ramp_hit = hit_left || hit_right;
            if (hit_left)
              xdir_nx = DIR_RIGHT;
            else if (hit_right)
              xdir_nx = DIR_LEFT;

            if ({1'b0, ballYValue} <= YMIN_E && yDirection == DIR_UP)
              ydir_nx = DIR_DOWN;
            else if ({1'b0, ballYValue} >= YMAX_E && yDirection == DIR_DOWN)
              ydir_nx = DIR_UP;
            else if (changeYDirection[1])
              ydir_nx = DIR_UP;
            else if (changeYDirection[0])
              ydir_nx = DIR_DOWN;

            // Motion uses the freshly decided directions; the extra bit
            // keeps the sum from wrapping before the clamp.
            if (xdir_nx == DIR_RIGHT)
              x_sum = {1'b0, ballXValue} + vx;
            else
              x_sum = ({1'b0, ballXValue} < XMIN_E + vx) ? XMIN_E : {1'b0, ballXValue} - vx;
            if (x_sum > XMAX_E) x_sum = XMAX_E;
            if (x_sum < XMIN_E) x_sum = XMIN_E;

            if (ydir_nx == DIR_DOWN)
              y_sum = {1'b0, ballYValue} + vy;
            else
              y_sum = ({1'b0, ballYValue} < YMIN_E + vy) ? YMIN_E : {1'b0, ballYValue} - vy;
            if (y_sum > YMAX_E) y_sum = YMAX_E;
            if (y_sum < YMIN_E) y_sum = YMIN_E;

            x_nx = x_sum[X_WIDTH-1:0];
            y_nx = y_sum[Y_WIDTH-1:0];
          end
        end
        default: state_nx = SERVE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= SERVE;
      serve_cnt  <= '0;
      ballXValue <= XSTART;
      ballYValue <= YSTART;
      xDirection <= DIR_LEFT;
      yDirection <= DIR_UP;
      missLeft   <= 1'b0;
      missRight  <= 1'b0;
    end else begin
      state      <= state_nx;
      serve_cnt  <= serve_nx;
      ballXValue <= x_nx;
      ballYValue <= y_nx;
      xDirection <= xdir_nx;
      yDirection <= ydir_nx;
      missLeft   <= miss_l_nx;
      missRight  <= miss_r_nx;
    end
  end

endmodule

// File: tb/tb_ball_kinematics.sv
// Directed bench for ball_kinematics with hand-computed trajectories.
module tb_ball_kinematics;

  logic        clock = 1'b0;
  logic        reset;
  logic        stepEnable;
  logic        paddleHitLeft;
  logic        paddleHitRight;
  logic [1:0]  changeYDirection;
  logic [7:0]  ballXValue;
  logic [8:0]  ballYValue;
  logic        xDirection;
  logic        yDirection;
  logic [1:0]  speedLevel;
  logic        inPlay;
  logic        missLeft;
  logic        missRight;

  int checks = 0;
  int errors = 0;

  ball_kinematics dut (
    .clock            (clock),
    .reset            (reset),
    .stepEnable       (stepEnable),
    .paddleHitLeft    (paddleHitLeft),
    .paddleHitRight   (paddleHitRight),
    .changeYDirection (changeYDirection),
    .ballXValue       (ballXValue),
    .ballYValue       (ballYValue),
    .xDirection       (xDirection),
    .yDirection       (yDirection),
    .speedLevel       (speedLevel),
    .inPlay           (inPlay),
    .missLeft         (missLeft),
    .missRight        (missRight)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic hl, input logic hr, input logic [1:0] cy);
    stepEnable       = 1'b1;
    paddleHitLeft    = hl;
    paddleHitRight   = hr;
    changeYDirection = cy;
    @(posedge clock);
    #1;
    stepEnable       = 1'b0;
    paddleHitLeft    = 1'b0;
    paddleHitRight   = 1'b0;
    changeYDirection = 2'b00;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 2'b00);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic check_pos(input string tag, input int x, input int y);
    check({tag, "_x"}, 32'(ballXValue), 32'(x));
    check({tag, "_y"}, 32'(ballYValue), 32'(y));
  endtask

  initial begin
    int vel;
    int x_exp;
    int y_exp;
    reset = 1'b1; stepEnable = 1'b0; paddleHitLeft = 1'b0;
    paddleHitRight = 1'b0; changeYDirection = 2'b00;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    // Reset state
    check_pos("rst", 115, 240);
    check("rst_xdir", 32'(xDirection), 0);
    check("rst_ydir", 32'(yDirection), 0);
    check("rst_level", 32'(speedLevel), 0);
    check("rst_inplay", 32'(inPlay), 0);
    check("rst_missl", 32'(missLeft), 0);
    check("rst_missr", 32'(missRight), 0);

    // Serve delay and first move
    ticks(59);
    check_pos("serve59", 115, 240);
    check("serve59_inplay", 32'(inPlay), 0);
    tick(1'b0, 1'b0, 2'b00);
    check("serve60_inplay", 32'(inPlay), 1);
    check_pos("serve60", 115, 240);
    tick(1'b0, 1'b0, 2'b00);
    check_pos("first_move", 114, 239);
    repeat (3) @(posedge clock);
    #1;
    check_pos("idle_hold", 114, 239);

    // Top wall bounce
    ticks(64);
    check_pos("at_top", 50, 175);
    tick(1'b0, 1'b0, 2'b00);
    check("top_ydir", 32'(yDirection), 1);
    check_pos("top_bounce", 49, 176);

    // Left miss
    ticks(29);
    check_pos("at_left", 20, 205);
    tick(1'b0, 1'b0, 2'b00);
    check("missl_pulse", 32'(missLeft), 1);
    check("missl_other", 32'(missRight), 0);
    check_pos("missl", 115, 205);
    check("missl_xdir", 32'(xDirection), 0);
    check("missl_ydir", 32'(yDirection), 1);
    check("missl_inplay", 32'(inPlay), 0);
    @(posedge clock);
    #1;
    check("missl_end", 32'(missLeft), 0);

    // Bottom wall bounce then right miss
    ticks(60);
    check("reserve_inplay", 32'(inPlay), 1);
    tick(1'b0, 1'b0, 2'b00);
    check_pos("reserve_move", 114, 206);
    tick(1'b1, 1'b0, 2'b00);
    check("lefthit_xdir", 32'(xDirection), 1);
    check_pos("lefthit", 115, 207);
    ticks(103);
    check_pos("at_bottom", 218, 310);
    tick(1'b0, 1'b0, 2'b00);
    check("bottom_ydir", 32'(yDirection), 0);
    check_pos("bottom_bounce", 219, 309);
    tick(1'b0, 1'b0, 2'b00);
    check_pos("at_right", 220, 308);
    tick(1'b0, 1'b0, 2'b00);
    check("missr_pulse", 32'(missRight), 1);
    check("missr_other", 32'(missLeft), 0);
    check_pos("missr", 115, 308);
    check("missr_xdir", 32'(xDirection), 1);
    check("missr_inplay", 32'(inPlay), 0);
    @(posedge clock);
    #1;
    check("missr_end", 32'(missRight), 0);

    // Paddle hit with both Y bits at X=21
    do_reset();
    ticks(60);
    ticks(94);
    check_pos("near_left", 21, 204);
    tick(1'b1, 1'b0, 2'b11);
    check("both_xdir", 32'(xDirection), 1);
    check("both_ydir", 32'(yDirection), 0);
    check_pos("both", 22, 203);

    // Speed ramp; serve ignores paddle inputs
    do_reset();
    tick(1'b1, 1'b1, 2'b10);
    check("serve_ign_xdir", 32'(xDirection), 0);
    check("serve_ign_ydir", 32'(yDirection), 0);
    check_pos("serve_ign", 115, 240);
    ticks(59);
    y_exp = 240;
    for (int i = 1; i <= 12; i++) begin
      vel = 1 + (i - 1) / 4;
      tick(i % 2 == 1, i % 2 == 0, 2'b00);
      y_exp -= vel;
      x_exp = (i % 2 == 1) ? 115 + vel : 115;
      check($sformatf("ramp%0d_level", i), 32'(speedLevel), 32'(i / 4));
      check_pos($sformatf("ramp%0d", i), x_exp, y_exp);
    end
    tick(1'b0, 1'b0, 2'b00);
    check_pos("v4_step", 111, 212);
    for (int i = 13; i <= 16; i++) begin
      tick(i % 2 == 1, i % 2 == 0, 2'b00);
      check($sformatf("sat%0d_level", i), 32'(speedLevel), 3);
      check($sformatf("sat%0d_x", i), 32'(ballXValue), (i % 2 == 1) ? 115 : 111);
    end

    // Reset mid-PLAY at level 2, with a tick and hit on the same edge
    do_reset();
    ticks(60);
    for (int i = 1; i <= 8; i++) tick(i % 2 == 1, i % 2 == 0, 2'b00);
    check("pre_rst_level", 32'(speedLevel), 2);
    check_pos("pre_rst", 115, 228);
    reset = 1'b1; stepEnable = 1'b1; paddleHitLeft = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0; stepEnable = 1'b0; paddleHitLeft = 1'b0;
    check_pos("mid_rst", 115, 240);
    check("mid_rst_level", 32'(speedLevel), 0);
    check("mid_rst_inplay", 32'(inPlay), 0);
    check("mid_rst_xdir", 32'(xDirection), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
